controller_poller: RTL and testbench

- FPGA-side master for two serial (NES-style) gamepads that share one latch line and one serial clock line, with a separate data line per pad.
- On each start request: pulses latch, generates 8 serial clock pulses, and shifts in 8 active-low bits per pad through 2-flop synchronizers.
- Publishes active-high button bytes and a done strobe to the memory-mapped I/O registers.

---
 rtl/controller_poller_if.sv | 22 ++
 rtl/controller_poller.sv | 119 +++++++++++
 tb/tb_controller_poller.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_poller_if.sv
// rtl/controller_poller_if.sv - pad bus and register-side signals of the two-pad poller
interface controller_poller_if;
    logic       start;
    logic       ctrl_latch;
    logic       ctrl_clk;
    logic       ctrl_data_1_B;
    logic       ctrl_data_2_B;
    logic [7:0] buttons_1;
    logic [7:0] buttons_2;
    logic       busy;
    logic       done;

    modport master (
        input  start, ctrl_data_1_B, ctrl_data_2_B,
        output ctrl_latch, ctrl_clk, buttons_1, buttons_2, busy, done
    );

    modport slave (
        output start, ctrl_data_1_B, ctrl_data_2_B,
        input  ctrl_latch, ctrl_clk, buttons_1, buttons_2, busy, done
    );
endinterface

// File: rtl/controller_poller.sv
// rtl/controller_poller.sv - latches and serially reads two NES-style pads sharing latch/clock lines
module controller_poller #(
    parameter int LATCH_CYCLES = 12,
    parameter int HALF_PERIOD  = 6
) (
    input  logic                clk,
    input  logic                rst,
    controller_poller_if.master bus
);
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int CW = (LW > HW) ? LW : HW;
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [1:0]    r_sync_1;
    logic [1:0]    r_sync_2;
    logic [7:0]    r_sr_1;
    logic [7:0]    r_sr_2;
    logic [7:0]    r_buttons_1;
    logic [7:0]    r_buttons_2;
    logic          r_latch;
    logic          r_cclk;
    logic          r_busy;
    logic          r_done;
    logic          w_phase_end;
    logic          w_latch;
    logic          w_cclk;
    logic          w_busy;
    logic          w_done;

    assign w_phase_end = (r_state == S_LATCH) ? (r_cnt == LATCH_LAST) : (r_cnt == HALF_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are decoded from the next state and registered, so they line up with r_state.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_LATCH;
            S_LATCH: if (w_phase_end) w_next = S_LOW;
            S_LOW:   if (w_phase_end) w_next = S_HIGH;
            S_HIGH:  if (w_phase_end) w_next = (r_bit == 3'd7) ? S_DONE : S_LOW;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_latch = (w_next == S_LATCH);
        w_cclk  = (w_next == S_HIGH);
        w_busy  = (w_next == S_LATCH) || (w_next == S_LOW) || (w_next == S_HIGH);
        w_done  = (w_next == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_sync_1    <= 2'b11;
            r_sync_2    <= 2'b11;
            r_sr_1      <= '0;
            r_sr_2      <= '0;
            r_buttons_1 <= '0;
            r_buttons_2 <= '0;
            r_latch     <= 1'b0;
            r_cclk      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_sync_1 <= {r_sync_1[0], bus.ctrl_data_1_B};
            r_sync_2 <= {r_sync_2[0], bus.ctrl_data_2_B};

            if ((w_next != r_state) || (r_state == S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (r_state == S_LATCH) begin
                r_bit <= '0;
            end else if ((r_state == S_HIGH) && w_phase_end) begin
                r_bit <= r_bit + 3'd1;
            end

            // Sample at the end of each low phase; first bit received lands in the MSB.
            if ((r_state == S_LOW) && w_phase_end) begin
                r_sr_1 <= {r_sr_1[6:0], ~r_sync_1[1]};
                r_sr_2 <= {r_sr_2[6:0], ~r_sync_2[1]};
            end

            if (w_next == S_DONE) begin
                r_buttons_1 <= r_sr_1;
                r_buttons_2 <= r_sr_2;
            end

            r_latch <= w_latch;
            r_cclk  <= w_cclk;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign bus.ctrl_latch = r_latch;
    assign bus.ctrl_clk   = r_cclk;
    assign bus.buttons_1  = r_buttons_1;
    assign bus.buttons_2  = r_buttons_2;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_controller_poller.sv
// tb/tb_controller_poller.sv - pad models, scoreboard and vector table for controller_poller
module tb_controller_poller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    controller_poller_if bus0();
    controller_poller_if bus1();

    controller_poller dut0 (.clk(clk), .rst(rst), .bus(bus0));
    controller_poller #(.LATCH_CYCLES(2), .HALF_PERIOD(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic       w_busy [2];
    logic       w_done [2];
    logic       w_latch[2];
    logic       w_cclk [2];
    logic [7:0] w_b1   [2];
    logic [7:0] w_b2   [2];
    logic       start_q[2];

    assign w_busy[0] = bus0.busy;        assign w_busy[1] = bus1.busy;
    assign w_done[0] = bus0.done;        assign w_done[1] = bus1.done;
    assign w_latch[0] = bus0.ctrl_latch; assign w_latch[1] = bus1.ctrl_latch;
    assign w_cclk[0] = bus0.ctrl_clk;    assign w_cclk[1] = bus1.ctrl_clk;
    assign w_b1[0] = bus0.buttons_1;     assign w_b1[1] = bus1.buttons_1;
    assign w_b2[0] = bus0.buttons_2;     assign w_b2[1] = bus1.buttons_2;
    assign bus0.start = start_q[0];
    assign bus1.start = start_q[1];

    // Pad models: index 2*dut + pad. Pressed buttons are 1 in pad_val; the line is active low.
    logic [7:0]  pad_val [4];
    logic [7:0]  pad_sr  [4];
    bit          pad_disc[4];
    bit          pad_pend[4];
    int          pad_cd  [4];
    bit          cclk_prev[2];
    int unsigned jit_max;

    assign bus0.ctrl_data_1_B = pad_disc[0] | ~pad_sr[0][7];
    assign bus0.ctrl_data_2_B = pad_disc[1] | ~pad_sr[1][7];
    assign bus1.ctrl_data_1_B = pad_disc[2] | ~pad_sr[2][7];
    assign bus1.ctrl_data_2_B = pad_disc[3] | ~pad_sr[3][7];

    always @(negedge clk) begin
        int dd;
        for (int k = 0; k < 4; k++) begin
            dd = k / 2;
            if (w_latch[dd]) begin
                pad_sr[k]   = pad_val[k];
                pad_pend[k] = 1'b0;
            end else begin
                if (w_cclk[dd] && !cclk_prev[dd]) begin
                    pad_pend[k] = 1'b1;
                    pad_cd[k]   = int'($urandom_range(jit_max, 0));
                end
                if (pad_pend[k]) begin
                    if (pad_cd[k] == 0) begin
                        pad_sr[k]   = {pad_sr[k][6:0], 1'b0};
                        pad_pend[k] = 1'b0;
                    end else begin
                        pad_cd[k] = pad_cd[k] - 1;
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) cclk_prev[k] = w_cclk[k];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        int         dut;
        logic [7:0] e1;
        logic [7:0] e2;
    } exp_t;
    exp_t sb_q[$];

    int busy_run[2], last_busy[2], latch_run[2], last_latch[2];
    int hi_run[2], last_hi[2], lo_run[2], last_lo[2];
    int done_cnt[2], latch_rises[2], cclk_rises[2];
    bit latch_prev[2], cclk_prev_m[2];

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (w_busy[k]) busy_run[k]++;
            else if (busy_run[k] != 0) begin last_busy[k] = busy_run[k]; busy_run[k] = 0; end
            if (w_latch[k]) latch_run[k]++;
            else if (latch_run[k] != 0) begin last_latch[k] = latch_run[k]; latch_run[k] = 0; end
            if (w_busy[k] && !w_latch[k]) begin
                if (w_cclk[k]) begin
                    hi_run[k]++;
                    if (lo_run[k] != 0) begin last_lo[k] = lo_run[k]; lo_run[k] = 0; end
                end else begin
                    lo_run[k]++;
                    if (hi_run[k] != 0) begin last_hi[k] = hi_run[k]; hi_run[k] = 0; end
                end
            end else begin
                if (hi_run[k] != 0) begin last_hi[k] = hi_run[k]; hi_run[k] = 0; end
                if (lo_run[k] != 0) begin last_lo[k] = lo_run[k]; lo_run[k] = 0; end
            end
            if (w_latch[k] && !latch_prev[k]) latch_rises[k]++;
            if (w_cclk[k] && !cclk_prev_m[k]) cclk_rises[k]++;
            latch_prev[k]  = w_latch[k];
            cclk_prev_m[k] = w_cclk[k];
            if (w_done[k]) begin
                done_cnt[k]++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_dut", k, e.dut);
                    check("sb_buttons_1", int'(w_b1[k]), int'(e.e1));
                    check("sb_buttons_2", int'(w_b2[k]), int'(e.e2));
                end
            end
        end
    end

    task automatic pulse_start(input int k);
        @(negedge clk);
        start_q[k] = 1'b1;
        @(negedge clk);
        start_q[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (w_done[k]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    typedef struct packed {
        int          dut;
        int unsigned jit;
        logic [7:0]  p1;
        logic [7:0]  p2;
        bit          d1;
        bit          d2;
        logic [7:0]  e1;
        logic [7:0]  e2;
        int          lat;
        int          half;
        int          len;
    } vec_t;

    task automatic run_vec(input vec_t v);
        bit ok;
        int cr;
        pad_val[2*v.dut]   = v.p1;
        pad_val[2*v.dut+1] = v.p2;
        pad_disc[2*v.dut]   = v.d1;
        pad_disc[2*v.dut+1] = v.d2;
        jit_max = v.jit;
        cr = cclk_rises[v.dut];
        sb_q.push_back('{dut: v.dut, e1: v.e1, e2: v.e2});
        pulse_start(v.dut);
        wait_done(v.dut, ok);
        check("done_seen", int'(ok), 1);
        @(negedge clk);
        check("done_one_cycle", int'(w_done[v.dut]), 0);
        check("busy_len", last_busy[v.dut], v.len);
        check("latch_len", last_latch[v.dut], v.lat);
        check("cclk_high_len", last_hi[v.dut], v.half);
        check("cclk_low_len", last_lo[v.dut], v.half);
        check("cclk_pulses", cclk_rises[v.dut] - cr, 8);
        pad_disc[2*v.dut]   = 1'b0;
        pad_disc[2*v.dut+1] = 1'b0;
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
        bit ok;
        bit hold_ok;
        int d0;
        int lr;

        vecs[0] = '{dut: 0, jit: 0, p1: 8'h81, p2: 8'h3C, d1: 0, d2: 0, e1: 8'h81, e2: 8'h3C, lat: 12, half: 6, len: 108};
        vecs[1] = '{dut: 0, jit: 0, p1: 8'hFF, p2: 8'h00, d1: 0, d2: 0, e1: 8'hFF, e2: 8'h00, lat: 12, half: 6, len: 108};
        vecs[2] = '{dut: 0, jit: 0, p1: 8'h5A, p2: 8'hC3, d1: 0, d2: 1, e1: 8'h5A, e2: 8'h00, lat: 12, half: 6, len: 108};
        vecs[3] = '{dut: 1, jit: 2, p1: 8'h81, p2: 8'h3C, d1: 0, d2: 0, e1: 8'h81, e2: 8'h3C, lat: 2, half: 4, len: 66};
        vecs[4] = '{dut: 1, jit: 2, p1: 8'hA7, p2: 8'h1E, d1: 0, d2: 0, e1: 8'hA7, e2: 8'h1E, lat: 2, half: 4, len: 66};
        vecs[5] = '{dut: 1, jit: 2, p1: 8'hE7, p2: 8'hFF, d1: 1, d2: 0, e1: 8'h00, e2: 8'hFF, lat: 2, half: 4, len: 66};

        rst = 1'b1;
        jit_max = 0;
        for (int k = 0; k < 2; k++) start_q[k] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pad_val[k] = 8'h00; pad_disc[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(w_busy[0]), 0);
        check("reset_latch", int'(w_latch[0]), 0);
        check("reset_cclk", int'(w_cclk[0]), 0);
        check("reset_done", int'(w_done[0]), 0);
        check("reset_buttons_1", int'(w_b1[0]), 0);
        check("reset_buttons_2", int'(w_b2[0]), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            v = '{dut: 0, jit: 0, p1: 8'h00, p2: 8'hFF, d1: 0, d2: 0, e1: 8'h00, e2: 8'hFF, lat: 12, half: 6, len: 108};
            v.p1 = 8'h80 >> i;
            v.e1 = 8'(1 << (7 - i));
            run_vec(v);
        end

        pad_val[0] = 8'h81; pad_val[1] = 8'h3C;
        pulse_start(0);
        repeat (4) @(negedge clk);
        check("pre_rst_latch", int'(w_latch[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_latch", int'(w_latch[0]), 0);
        check("rst_async_busy", int'(w_busy[0]), 0);
        check("rst_async_cclk", int'(w_cclk[0]), 0);
        check("rst_async_buttons_1", int'(w_b1[0]), 0);
        check("rst_async_buttons_2", int'(w_b2[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt[0];
        repeat (200) @(negedge clk);
        check("no_done_after_rst", done_cnt[0] - d0, 0);

        pad_val[0] = 8'h42; pad_val[1] = 8'h24;
        d0 = done_cnt[0];
        lr = latch_rises[0];
        sb_q.push_back('{dut: 0, e1: 8'h42, e2: 8'h24});
        pulse_start(0);
        repeat (3) @(negedge clk);
        pulse_start(0);
        repeat (53) @(negedge clk);
        pulse_start(0);
        wait_done(0, ok);
        check("busy_start_done_seen", int'(ok), 1);
        @(negedge clk);
        check("busy_start_len", last_busy[0], 108);
        repeat (150) @(negedge clk);
        check("busy_start_one_done", done_cnt[0] - d0, 1);
        check("busy_start_one_latch", latch_rises[0] - lr, 1);

        pad_val[0] = 8'hA5; pad_val[1] = 8'hA5;
        sb_q.push_back('{dut: 0, e1: 8'hA5, e2: 8'hA5});
        pulse_start(0);
        wait_done(0, ok);
        check("b2b_first_done", int'(ok), 1);
        @(negedge clk);
        pad_val[0] = 8'h5A; pad_val[1] = 8'h5A;
        sb_q.push_back('{dut: 0, e1: 8'h5A, e2: 8'h5A});
        start_q[0] = 1'b1;
        @(negedge clk);
        start_q[0] = 1'b0;
        hold_ok = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (w_done[0]) begin ok = 1'b1; break; end
            if (w_b1[0] != 8'hA5 || w_b2[0] != 8'hA5) hold_ok = 1'b0;
            @(negedge clk);
        end
        check("b2b_second_done", int'(ok), 1);
        check("b2b_hold_between_polls", int'(hold_ok), 1);
        @(negedge clk);
        check("b2b_busy_len", last_busy[0], 108);
        check("b2b_buttons_after", int'(w_b1[0]), 8'h5A);

        repeat (5) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
